rvb_prot_pipe: RTL

//  Pipelined, parametrised packed-rotate unit for the ISE datapath. Rotates each

---
 rtl/rvb_prot_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rvb_prot_pipe.sv
// rvb_prot_pipe: packed-lane rotate (nibble/byte/half/word/dword) with valid/ready on both sides.
// PIPE=1 splits the log-level rotate network across two registered stages; PIPE=0 uses one.
module rvb_prot_pipe #(
    parameter int XLEN  = 32,
    parameter int PIPE  = 1,
    parameter int TAG_W = 5
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_rs1,
    input  logic [$clog2(XLEN)-1:0] in_amt,
    input  logic [2:0]              in_esize,
    input  logic                    in_left,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_rd,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_err
);
    localparam int AW = $clog2(XLEN);

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   amt_t;

    // One network level: rotate every lane of width 4<<esz right by 2^lvl.
    function automatic word_t ror_level(word_t d, logic [2:0] esz, int lvl);
        int    e;
        int    s;
        word_t keep;
        e    = 4 << esz;
        s    = 1 << lvl;
        keep = '0;
        if (e <= s) begin
            return d;
        end else begin
            for (int j = 0; j < XLEN; j++) begin
                if ((j & (e - 1)) < (e - s)) keep = keep | (word_t'(1) << j);
            end
            return ((d >> s) & keep) | ((d << (e - s)) & ~keep);
        end
    endfunction

    function automatic word_t ror_levels(word_t d, logic [2:0] esz, amt_t amt, int lo, int hi);
        word_t r;
        r = d;
        for (int l = lo; l < hi; l++) begin
            if (((int'(amt) >> l) & 1) != 0) r = ror_level(r, esz, l);
        end
        return r;
    endfunction

    // Left rotates become right rotates by (E-k) mod E so a single network serves both.
    function automatic amt_t right_amt(logic [2:0] esz, amt_t amt, logic left);
        int e;
        int k;
        e = 4 << esz;
        k = int'(amt) & (e - 1);
        if (left) k = (e - k) & (e - 1);
        return amt_t'(k);
    endfunction

    logic       in_err;
    logic [2:0] in_esz;
    amt_t       in_ramt;
    logic       out_adv;

    // Illegal sizes travel as nibble ops so the network stays bounded; the result is zeroed later.
    always_comb begin
        in_err  = !((in_esize <= 3'd3) || (in_esize == 3'd4 && XLEN == 64));
        in_esz  = in_err ? 3'd0 : in_esize;
        in_ramt = right_amt(in_esz, in_amt, in_left);
    end

    assign out_adv = !out_valid || out_ready;

    generate
        if (PIPE != 0) begin : g_two
            logic             s1_valid;
            logic             s1_err;
            word_t            s1_data;
            amt_t             s1_amt;
            logic [2:0]       s1_esz;
            logic [TAG_W-1:0] s1_tag;

            assign in_ready = !flush && (!s1_valid || out_adv);

            always_ff @(posedge g_clk or negedge g_resetn) begin
                if (!g_resetn) begin
                    s1_valid <= 1'b0;
                    s1_err   <= 1'b0;
                    s1_data  <= '0;
                    s1_amt   <= '0;
                    s1_esz   <= '0;
                    s1_tag   <= '0;
                end else if (flush) begin
                    s1_valid <= 1'b0;
                end else if (!s1_valid || out_adv) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_err  <= in_err;
                        s1_data <= ror_levels(in_rs1, in_esz, in_ramt, 0, 2);
                        s1_amt  <= in_ramt;
                        s1_esz  <= in_esz;
                        s1_tag  <= in_tag;
                    end
                end
            end

            always_ff @(posedge g_clk or negedge g_resetn) begin
                if (!g_resetn) begin
                    out_valid <= 1'b0;
                    out_rd    <= '0;
                    out_tag   <= '0;
                    out_err   <= 1'b0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else if (out_adv) begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_rd  <= s1_err ? '0 : ror_levels(s1_data, s1_esz, s1_amt, 2, AW);
                        out_tag <= s1_tag;
                        out_err <= s1_err;
                    end
                end
            end
        end else begin : g_one
            assign in_ready = !flush && out_adv;

            always_ff @(posedge g_clk or negedge g_resetn) begin
                if (!g_resetn) begin
                    out_valid <= 1'b0;
                    out_rd    <= '0;
                    out_tag   <= '0;
                    out_err   <= 1'b0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else if (out_adv) begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        out_rd  <= in_err ? '0 : ror_levels(in_rs1, in_esz, in_ramt, 0, AW);
                        out_tag <= in_tag;
                        out_err <= in_err;
                    end
                end
            end
        end
    endgenerate

endmodule
